// File: rtl/arcane_rr_arbiter.sv
// Round-robin arbiter with lock-until-release ownership and one idle cycle between grants.
// Optional hold timeout compiled in with macro ARCANE_ARB_TIMEOUT_EN.

module arcane_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_HOLD  = 64,
  parameter int IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic                 release_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [IDX_WIDTH-1:0] gnt_idx_o,
  output logic                 gnt_valid_o,
  output logic                 timeout_o
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_r;
  logic [IDX_WIDTH-1:0] rr_ptr_r;
  logic [IDX_WIDTH-1:0] gnt_idx_r;
  logic [NUM_REQ-1:0]   gnt_r;
  logic                 gnt_valid_r;
  logic [IDX_WIDTH-1:0] pick_s;
  logic                 tmo_s;
  logic [IDX_WIDTH-1:0] next_ptr_s;

  // First set request at or after ptr, wrapping from NUM_REQ-1 back to 0.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0]   req,
                                                   input logic [IDX_WIDTH-1:0] ptr);
    logic [IDX_WIDTH-1:0] sel;
    logic [NUM_REQ-1:0]   req_sh;
    logic                 found;
    int                   pos;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end else begin
        pos = pos;
      end
      req_sh = req >> pos;
      if (!found && req_sh[0]) begin
        sel   = IDX_WIDTH'(pos);
        found = 1'b1;
      end else begin
        sel   = sel;
      end
    end
    return sel;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_WIDTH-1:0] idx);
    return NUM_REQ'(1'b1) << idx;
  endfunction

`ifdef ARCANE_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt_r;
  logic        timeout_r;

  // Hold limit reached this cycle; a simultaneous release wins and is not a timeout.
  always_comb begin
    tmo_s = 1'b0;
    if ((state_r == LOCKED) && !release_i && (hold_cnt_r == 16'(MAX_HOLD - 1))) begin
      tmo_s = 1'b1;
    end else begin
      tmo_s = 1'b0;
    end
  end

  assign timeout_o = timeout_r;
`else
  // Without the timeout feature the grant is held until release_i.
  always_comb begin
    tmo_s = 1'b0;
  end

  assign timeout_o = 1'b0;
`endif

  // Round-robin search and pointer advance past the current owner.
  always_comb begin
    pick_s     = rr_pick(req_i, rr_ptr_r);
    next_ptr_s = '0;
    if (gnt_idx_r == IDX_WIDTH'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_idx_r + IDX_WIDTH'(1'b1);
    end
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      gnt_idx_r   <= '0;
      gnt_r       <= '0;
      gnt_valid_r <= 1'b0;
`ifdef ARCANE_ARB_TIMEOUT_EN
      hold_cnt_r  <= 16'd0;
      timeout_r   <= 1'b0;
`endif
    end else begin
`ifdef ARCANE_ARB_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (|req_i) begin
            state_r     <= LOCKED;
            gnt_idx_r   <= pick_s;
            gnt_r       <= onehot(pick_s);
            gnt_valid_r <= 1'b1;
`ifdef ARCANE_ARB_TIMEOUT_EN
            hold_cnt_r  <= 16'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        LOCKED: begin
          if (release_i || tmo_s) begin
            state_r     <= IDLE;
            rr_ptr_r    <= next_ptr_s;
            gnt_idx_r   <= '0;
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
`ifdef ARCANE_ARB_TIMEOUT_EN
            timeout_r   <= tmo_s;
`endif
          end else begin
            state_r    <= LOCKED;
`ifdef ARCANE_ARB_TIMEOUT_EN
            hold_cnt_r <= hold_cnt_r + 16'd1;
`endif
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt_idx_r   <= '0;
          gnt_r       <= '0;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_r;
  assign gnt_idx_o   = gnt_idx_r;
  assign gnt_valid_o = gnt_valid_r;

`ifndef SYNTHESIS
  arcane_rr_arbiter_chk #(
    .NUM_REQ  (NUM_REQ),
    .MAX_HOLD (MAX_HOLD)
  ) u_chk (
    .clk       (clk_i),
    .rst       (rst_i),
    .gnt       (gnt_r),
    .gnt_valid (gnt_valid_r)
  );
`endif

endmodule

// Simulation-only property checks on the grant vector.
module arcane_rr_arbiter_chk #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 64
) (
  input logic               clk,
  input logic               rst,
  input logic [NUM_REQ-1:0] gnt,
  input logic               gnt_valid
);

  a_param_range : assert property (@(posedge clk)
    (NUM_REQ >= 1) && (NUM_REQ <= 16) && (MAX_HOLD >= 1) && (MAX_HOLD <= 65535));

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

  a_gnt_when_valid : assert property (@(posedge clk) disable iff (rst)
    gnt_valid |-> (gnt != '0));

endmodule

// File: tb/tb_arcane_rr_arbiter.sv
// Randomized and directed bench for arcane_rr_arbiter against a cycle-level ownership model.
module tb_arcane_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] req_i;
  logic         release_i;
  logic [N-1:0] gnt_o;
  logic [1:0]   gnt_idx_o;
  logic         gnt_valid_o;
  logic         timeout_o;

  int n_pass  = 0;
  int n_total = 0;

  // Model: who owns the resource (-1 none), where the search starts, how long held.
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_tmo;

`ifdef ARCANE_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  arcane_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .release_i   (release_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic rel);
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && r[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
      end
      m_held = 0;
    end else begin
      m_held++;
      if (rel || (TMO_EN && m_held == MH)) begin
        m_tmo   = !rel;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".gnt"},   32'(gnt_o),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check({tag, ".idx"},   32'(gnt_idx_o),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check({tag, ".valid"}, 32'(gnt_valid_o), 32'(m_owner >= 0));
    check({tag, ".tmo"},   32'(timeout_o),   32'(m_tmo));
  endtask

  // Called at a negedge: drive, clock, then compare at the following negedge.
  task automatic cycle(input string tag, input logic [N-1:0] r, input logic rel);
    req_i     = r;
    release_i = rel;
    @(posedge clk_i);
    model_step(r, rel);
    @(negedge clk_i);
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_i     = 1'b1;
    req_i     = '0;
    release_i = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    compare_all({tag, ".rst"});
  endtask

  initial begin
    rst_i     = 1'b0;
    req_i     = '0;
    release_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    do_reset("por");

    // Single requester gets the grant one cycle later.
    cycle("r030", 4'b0100, 1'b0);
    check("r030.idx_const", 32'(gnt_idx_o), 32'd2);
    check("r030.gnt_const", 32'(gnt_o), 32'h4);
    cycle("r030.rel", 4'b0000, 1'b1);
    cycle("r030.ign_rel", 4'b0000, 1'b1);

    // Full contention: rotating order with an idle gap after each release.
    do_reset("r031");
    for (int k = 0; k < 5; k++) begin
      cycle("r031.grant", 4'b1111, 1'b0);
      check("r031.order", 32'(gnt_idx_o), 32'(k % N));
      cycle("r031.rel", 4'b1111, 1'b1);
      check("r031.gap", 32'(gnt_valid_o), 32'd0);
    end

    // Owner dropping its request keeps the lock; wrap search afterwards.
    do_reset("r032");
    cycle("r032.grant", 4'b0010, 1'b0);
    for (int k = 0; k < 3; k++) cycle("r032.hold", 4'b0000, 1'b0);
    check("r032.held", 32'(gnt_o), 32'h2);
    cycle("r032.rel", 4'b0000, 1'b1);
    cycle("r032.wrap", 4'b0011, 1'b0);
    check("r032.wrap_idx", 32'(gnt_idx_o), 32'd0);

    // Reset while owner 3 holds the lock.
    cycle("r033.rel0", 4'b0000, 1'b1);
    cycle("r033.grant", 4'b1000, 1'b0);
    check("r033.owner3", 32'(gnt_idx_o), 32'd3);
    do_reset("r033");
    cycle("r033.after", 4'b1001, 1'b0);
    check("r033.idx0", 32'(gnt_idx_o), 32'd0);

`ifdef ARCANE_ARB_TIMEOUT_EN
    // Owner 2 never releases: forced release after MH locked cycles.
    do_reset("r034");
    cycle("r034.grant", 4'b0100, 1'b0);
    for (int k = 0; k < MH; k++) cycle("r034.hold", 4'b1100, 1'b0);
    check("r034.tmo", 32'(timeout_o), 32'd1);
    cycle("r034.next", 4'b1100, 1'b0);
    check("r034.next_idx", 32'(gnt_idx_o), 32'd3);
    check("r034.tmo_pulse", 32'(timeout_o), 32'd0);

    // Release on the timeout cycle is an ordinary release.
    do_reset("r035");
    cycle("r035.grant", 4'b0100, 1'b0);
    for (int k = 0; k < MH - 1; k++) cycle("r035.hold", 4'b0100, 1'b0);
    cycle("r035.rel", 4'b0100, 1'b1);
    check("r035.no_tmo", 32'(timeout_o), 32'd0);
    check("r035.valid", 32'(gnt_valid_o), 32'd0);
`endif

    // Random traffic with occasional resets.
    do_reset("rand");
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand.rst");
      end else begin
        cycle("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arcane_rr_arbiter.md
ARCANE_RR_ARBITER -- requirements
Module: arcane_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the resource (legal range 1..16).
REQ-002 SHALL have parameter MAX_HOLD, default 64, hold-cycle limit used only when the timeout feature is compiled in (legal range 1..65535).
REQ-003 SHALL have parameter IDX_WIDTH, default (NUM_REQ==1 ? 1 : $clog2(NUM_REQ)), derived, not to be overridden.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port req_i, input, NUM_REQ, per-requester level request.
REQ-007 SHALL have port release_i, input, 1, current owner is done; one-cycle pulse or level.
REQ-008 SHALL have port gnt_o, output, NUM_REQ, one-hot grant, all-zero when no owner.
REQ-009 SHALL have port gnt_idx_o, output, IDX_WIDTH, binary index of the owner, 0 when no owner.
REQ-010 SHALL have port gnt_valid_o, output, 1, high while an owner holds the resource.
REQ-011 SHALL have port timeout_o, output, 1, one-cycle pulse on forced release (tied 0 when the feature is absent).

Function
REQ-012 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-013 In IDLE with any req_i bit set, SHALL select the first set bit at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0, and enter LOCKED on the next edge.
REQ-014 SHALL register all outputs; gnt_valid_o rises exactly 1 cycle after the edge at which req_i is sampled in IDLE.
REQ-015 SHALL decode gnt_o from the registered gnt_idx_o with a binary-to-onehot decode; gnt_o SHALL equal (1 << gnt_idx_o) when gnt_valid_o is high and all zeros otherwise.
REQ-016 In LOCKED, SHALL hold gnt_o and gnt_idx_o stable until release_i is sampled high, regardless of any req_i changes, including the owner's own request dropping.
REQ-017 When release_i is sampled high in LOCKED, SHALL return to IDLE; gnt_valid_o falls on the next cycle; rr_ptr becomes (owner+1) mod NUM_REQ.
REQ-018 SHALL insert a minimum one-cycle IDLE gap between consecutive grants, even when requests are pending at release.
REQ-019 SHALL ignore release_i while in IDLE.
REQ-020 SHALL leave rr_ptr unchanged while in IDLE with req_i all-zero.
REQ-021 With NUM_REQ==1, rr_ptr and gnt_idx_o SHALL remain 0, and gnt_o SHALL equal gnt_valid_o.

Reset
REQ-022 SHALL, on rst_i high, immediately and asynchronously set state=IDLE, rr_ptr=0, gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, timeout_o=0, hold counter=0.
REQ-023 Reset asserted in LOCKED SHALL drop the grant without a timeout_o pulse; the first grant after reset SHALL start its search from index 0.

Configuration
REQ-024 SHALL compile the hold timeout only when macro ARCANE_ARB_TIMEOUT_EN is defined.
REQ-025 With ARCANE_ARB_TIMEOUT_EN defined, SHALL count LOCKED cycles with a 16-bit counter cleared on entering LOCKED.
REQ-026 With ARCANE_ARB_TIMEOUT_EN defined, SHALL treat count reaching MAX_HOLD without release_i as a release: pulse timeout_o for 1 cycle, aligned with gnt_valid_o falling, and advance rr_ptr as in REQ-017.
REQ-027 With ARCANE_ARB_TIMEOUT_EN defined, if release_i and timeout coincide, SHALL treat the event as a normal release with timeout_o=0.
REQ-028 Without ARCANE_ARB_TIMEOUT_EN, SHALL contain no counter, SHALL tie timeout_o to 0, and SHALL hold the grant indefinitely.
REQ-029 SHALL, in non-synthesis simulation, assert that gnt_o is always $onehot0 and that gnt_o!=0 whenever gnt_valid_o is high.

Verification (NUM_REQ=4)
REQ-030 Reset, then req_i=4'b0100 -> next cycle gnt_o=4'b0100, gnt_idx_o=2, gnt_valid_o=1.
REQ-031 req_i=4'b1111 held, release_i pulsed each grant -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-032 Owner 1 drops req_i while LOCKED, no release_i -> gnt_o stays 4'b0010; after release_i, req_i=4'b0011 -> next grant is index 0 (wrap search from rr_ptr=2).
REQ-033 rst_i asserted mid-LOCKED with owner 3 -> outputs zero immediately; after deassertion, req_i=4'b1001 -> grant index 0.
REQ-034 With ARCANE_ARB_TIMEOUT_EN and MAX_HOLD=8, owner 2 never releases -> timeout_o pulses after 8 LOCKED cycles and the next grant goes to 3 if requested.
REQ-035 With ARCANE_ARB_TIMEOUT_EN and MAX_HOLD=8, release_i lands on the timeout cycle -> normal release, timeout_o stays 0.
